// File: rtl/vga_timing_scanout_if.sv
// vga_timing_scanout_if
//   Bundles the signals between the raster timing / scan-out stage and the
//   rest of the pong display path.
//   master : the timing generator. It drives coordinates, the VGA pins and
//            FRAME_START, and receives PIXEL.
//   slave  : the game engine and connector side. It drives PIXEL.
//   Signals
//     PIXEL        3   {R,G,B} answer from the engine
//     PIXEL_H/V    11  raw horizontal / vertical counters
//     VGA_R/G/B    1   blanked colour to the connector
//     VGA_HSYNC/VSYNC  syncs, polarity set by the timing generator
//     BLANK        1   1 = RGB on the pins is outside the visible area
//     FRAME_START  1   one-clock pulse at the start of each frame
interface vga_timing_scanout_if;
  logic [2:0]  PIXEL;
  logic [10:0] PIXEL_H;
  logic [10:0] PIXEL_V;
  logic        VGA_R;
  logic        VGA_G;
  logic        VGA_B;
  logic        VGA_HSYNC;
  logic        VGA_VSYNC;
  logic        BLANK;
  logic        FRAME_START;

  modport master (
    input  PIXEL,
    output PIXEL_H, PIXEL_V,
    output VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC, BLANK, FRAME_START
  );

  modport slave (
    output PIXEL,
    input  PIXEL_H, PIXEL_V,
    input  VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC, BLANK, FRAME_START
  );
endinterface

// File: rtl/vga_timing_scanout.sv
// vga_timing_scanout
//   Raster timing generator and scan-out stage. Free-running h/v counters
//   drive the engine coordinates; sync and visible-area flags are delayed
//   through a PIXEL_LATENCY-deep pipe so they line up with the engine's
//   PIXEL answer, then registered together with it onto the VGA pins.
//   Ports
//     VGA_CLOCK  in  pixel clock
//     RESET      in  asynchronous, active-high
//     io_vga     master modport of vga_timing_scanout_if (PIXEL in;
//                PIXEL_H/V, VGA_R/G/B, VGA_HSYNC/VSYNC, BLANK, FRAME_START out)
//
//   Phase FSM (one instance for h, one for v)
//     state      | meaning
//     PH_VISIBLE | counter inside the active area
//     PH_FRONT   | front porch
//     PH_SYNC    | sync pulse asserted
//     PH_BACK    | back porch, ends at the counter wrap
module vga_timing_scanout #(
  parameter int H_VISIBLE     = 800,
  parameter int H_FRONT       = 56,
  parameter int H_SYNC        = 120,
  parameter int H_BACK        = 64,
  parameter int V_VISIBLE     = 600,
  parameter int V_FRONT       = 37,
  parameter int V_SYNC        = 6,
  parameter int V_BACK        = 23,
  parameter bit H_SYNC_POL    = 1'b1,
  parameter bit V_SYNC_POL    = 1'b1,
  parameter int PIXEL_LATENCY = 1
) (
  input  logic                  VGA_CLOCK,
  input  logic                  RESET,
  vga_timing_scanout_if.master  io_vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_VIS_LAST   = 11'(H_VISIBLE - 1);
  localparam logic [10:0] H_FRONT_LAST = 11'(H_VISIBLE + H_FRONT - 1);
  localparam logic [10:0] H_SYNC_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_VIS_LAST   = 11'(V_VISIBLE - 1);
  localparam logic [10:0] V_FRONT_LAST = 11'(V_VISIBLE + V_FRONT - 1);
  localparam logic [10:0] V_SYNC_LAST  = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);

  // Counters are 11 bits; every phase needs at least one clock/line so the
  // FSMs never have to skip a state.
  if (H_TOTAL > 2047) begin : g_bad_h_total
    $error("vga_timing_scanout: H_TOTAL exceeds 2047");
  end
  if (V_TOTAL > 2047) begin : g_bad_v_total
    $error("vga_timing_scanout: V_TOTAL exceeds 2047");
  end
  if (PIXEL_LATENCY < 1 || PIXEL_LATENCY > 4) begin : g_bad_latency
    $error("vga_timing_scanout: PIXEL_LATENCY must be 1..4");
  end
  if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_phase
    $error("vga_timing_scanout: every timing phase must be at least 1");
  end

  typedef enum logic [1:0] {
    PH_VISIBLE = 2'd0,
    PH_FRONT   = 2'd1,
    PH_SYNC    = 2'd2,
    PH_BACK    = 2'd3
  } phase_t;

  logic [10:0] r_h;
  logic [10:0] r_v;
  logic        w_line_end;
  logic        w_frame_end;

  phase_t      r_h_phase;
  phase_t      w_h_phase_nxt;
  phase_t      r_v_phase;
  phase_t      w_v_phase_nxt;

  logic        w_hs_raw;
  logic        w_vs_raw;
  logic        w_vis_raw;
  logic [2:0]  r_pipe [PIXEL_LATENCY];   // {hs, vs, vis}, active-high
  logic [2:0]  w_tail;

  logic [2:0]  r_rgb;
  logic        r_blank;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_frame_start;

  // ---------------------------------------------------------------- counters
  always_comb begin
    w_line_end  = (r_h == H_LAST);
    w_frame_end = w_line_end && (r_v == V_LAST);
  end

  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_line_end ? 11'd0 : r_h + 11'd1;
      if (w_frame_end)
        r_v <= '0;
      else if (w_line_end)
        r_v <= r_v + 11'd1;
    end
  end

  // -------------------------------------------------------------- phase FSMs
  // The phase register advances on the same edge as its counter, so the
  // phase always describes the current r_h / r_v.
  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) begin
      r_h_phase <= PH_VISIBLE;
      r_v_phase <= PH_VISIBLE;
    end else begin
      r_h_phase <= w_h_phase_nxt;
      r_v_phase <= w_v_phase_nxt;
    end
  end

  always_comb begin
    w_h_phase_nxt = r_h_phase;
    case (r_h_phase)
      PH_VISIBLE: if (r_h == H_VIS_LAST)   w_h_phase_nxt = PH_FRONT;
      PH_FRONT:   if (r_h == H_FRONT_LAST) w_h_phase_nxt = PH_SYNC;
      PH_SYNC:    if (r_h == H_SYNC_LAST)  w_h_phase_nxt = PH_BACK;
      PH_BACK:    if (w_line_end)          w_h_phase_nxt = PH_VISIBLE;
      default:                             w_h_phase_nxt = PH_VISIBLE;
    endcase
  end

  always_comb begin
    w_v_phase_nxt = r_v_phase;
    if (w_line_end) begin
      case (r_v_phase)
        PH_VISIBLE: if (r_v == V_VIS_LAST)   w_v_phase_nxt = PH_FRONT;
        PH_FRONT:   if (r_v == V_FRONT_LAST) w_v_phase_nxt = PH_SYNC;
        PH_SYNC:    if (r_v == V_SYNC_LAST)  w_v_phase_nxt = PH_BACK;
        PH_BACK:    if (r_v == V_LAST)       w_v_phase_nxt = PH_VISIBLE;
        default:                             w_v_phase_nxt = PH_VISIBLE;
      endcase
    end
  end

  always_comb begin
    w_hs_raw  = (r_h_phase == PH_SYNC);
    w_vs_raw  = (r_v_phase == PH_SYNC);
    w_vis_raw = (r_h_phase == PH_VISIBLE) && (r_v_phase == PH_VISIBLE);
  end

  // ---------------------------------------------------------- latency match
  // Cleared pipe entries read as "blank, syncs inactive".
  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < PIXEL_LATENCY; i++)
        r_pipe[i] <= 3'b000;
    end else begin
      r_pipe[0] <= {w_hs_raw, w_vs_raw, w_vis_raw};
      for (int i = 1; i < PIXEL_LATENCY; i++)
        r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_tail = r_pipe[PIXEL_LATENCY-1];

  // ----------------------------------------------------------- output stage
  // FRAME_START is taken from the undelayed counters: it pulses on the clock
  // after the counters sit at (0,0), which also gives the pulse one clock
  // after reset release.
  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) begin
      r_rgb         <= 3'b000;
      r_blank       <= 1'b1;
      r_hsync       <= !H_SYNC_POL;
      r_vsync       <= !V_SYNC_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_rgb         <= w_tail[0] ? io_vga.PIXEL : 3'b000;
      r_blank       <= !w_tail[0];
      r_hsync       <= w_tail[2] ? H_SYNC_POL : !H_SYNC_POL;
      r_vsync       <= w_tail[1] ? V_SYNC_POL : !V_SYNC_POL;
      r_frame_start <= (r_h == 11'd0) && (r_v == 11'd0);
    end
  end

  assign io_vga.PIXEL_H     = r_h;
  assign io_vga.PIXEL_V     = r_v;
  assign io_vga.VGA_R       = r_rgb[2];
  assign io_vga.VGA_G       = r_rgb[1];
  assign io_vga.VGA_B       = r_rgb[0];
  assign io_vga.VGA_HSYNC   = r_hsync;
  assign io_vga.VGA_VSYNC   = r_vsync;
  assign io_vga.BLANK       = r_blank;
  assign io_vga.FRAME_START = r_frame_start;

endmodule

// File: tb/tb_vga_timing_scanout.sv
// tb_vga_timing_scanout
//   Two instances in a reduced mode (15 x 8 raster): one with latency 1 and
//   active-high syncs, one with latency 3 and active-low syncs. A bench-side
//   engine answers PIXEL from the coordinates LAT clocks earlier (111 outside
//   the visible columns). Expected pin values are queued per cycle from an
//   independent raster model and popped LAT+1 cycles later.
module tb_vga_timing_scanout;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int LAT_A = 1, LAT_B = 3;
  localparam bit POL_A = 1'b1, POL_B = 1'b0;

  logic VGA_CLOCK = 1'b0;
  logic RESET     = 1'b1;
  always #5 VGA_CLOCK = ~VGA_CLOCK;

  vga_timing_scanout_if if_a ();
  vga_timing_scanout_if if_b ();

  vga_timing_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(POL_A), .V_SYNC_POL(POL_A), .PIXEL_LATENCY(LAT_A)
  ) u_dut_a (
    .VGA_CLOCK (VGA_CLOCK),
    .RESET     (RESET),
    .io_vga    (if_a)
  );

  vga_timing_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(POL_B), .V_SYNC_POL(POL_B), .PIXEL_LATENCY(LAT_B)
  ) u_dut_b (
    .VGA_CLOCK (VGA_CLOCK),
    .RESET     (RESET),
    .io_vga    (if_b)
  );

  typedef struct packed {
    logic [2:0] rgb;
    logic       blank;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   hist_a[$];
  int   hist_b[$];

  int checks   = 0;
  int failures = 0;

  int mh, mv, cyc;
  bit prev_origin;
  int last_fs, hs_rise_cnt, hs_run, vs_run;
  bit hs_prev, vs_prev;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out(input int h, input int v, input bit pol);
    exp_t e;
    bit vis, hs, vs;
    vis = (h < HV) && (v < VV);
    hs  = (h >= HV + HF) && (h < HV + HF + HS);
    vs  = (v >= VV + VF) && (v < VV + VF + VS);
    e.rgb   = vis ? 3'(h % 8) : 3'b000;
    e.blank = !vis;
    e.hs    = hs ? pol : !pol;
    e.vs    = vs ? pol : !pol;
    return e;
  endfunction

  function automatic exp_t reset_out(input bit pol);
    exp_t e;
    e.rgb = 3'b000; e.blank = 1'b1; e.hs = !pol; e.vs = !pol;
    return e;
  endfunction

  function automatic logic [2:0] engine(input int h);
    return (h < HV) ? 3'(h % 8) : 3'b111;
  endfunction

  task automatic check_reset_pins(input string tag);
    chk({tag, "_a_h"},     if_a.PIXEL_H, 0);
    chk({tag, "_a_v"},     if_a.PIXEL_V, 0);
    chk({tag, "_a_pins"},  {if_a.VGA_R, if_a.VGA_G, if_a.VGA_B, if_a.BLANK,
                            if_a.VGA_HSYNC, if_a.VGA_VSYNC}, reset_out(POL_A));
    chk({tag, "_a_fs"},    if_a.FRAME_START, 0);
    chk({tag, "_b_h"},     if_b.PIXEL_H, 0);
    chk({tag, "_b_pins"},  {if_b.VGA_R, if_b.VGA_G, if_b.VGA_B, if_b.BLANK,
                            if_b.VGA_HSYNC, if_b.VGA_VSYNC}, reset_out(POL_B));
    chk({tag, "_b_fs"},    if_b.FRAME_START, 0);
  endtask

  // Called in the cycle where RESET drops; that cycle is cycle 0 at (0,0).
  task automatic start_model();
    q_a.delete(); q_b.delete(); hist_a.delete(); hist_b.delete();
    for (int i = 0; i <= LAT_A; i++) q_a.push_back(reset_out(POL_A));
    for (int i = 0; i <= LAT_B; i++) q_b.push_back(reset_out(POL_B));
    mh = 0; mv = 0; cyc = 0; prev_origin = 1'b0;
    last_fs = -1; hs_rise_cnt = 0; hs_run = 0; vs_run = 0;
    hs_prev = 1'b0; vs_prev = 1'b0;
  endtask

  task automatic do_cycle();
    exp_t e;
    bit   hs_now, vs_now;
    // scoreboard: pin values for the coordinates LAT+1 cycles back
    e = q_a.pop_front();
    chk("a_rgb",   {if_a.VGA_R, if_a.VGA_G, if_a.VGA_B}, e.rgb);
    chk("a_blank", if_a.BLANK, e.blank);
    chk("a_hsync", if_a.VGA_HSYNC, e.hs);
    chk("a_vsync", if_a.VGA_VSYNC, e.vs);
    e = q_b.pop_front();
    chk("b_rgb",   {if_b.VGA_R, if_b.VGA_G, if_b.VGA_B}, e.rgb);
    chk("b_blank", if_b.BLANK, e.blank);
    chk("b_hsync", if_b.VGA_HSYNC, e.hs);
    chk("b_vsync", if_b.VGA_VSYNC, e.vs);
    q_a.push_back(model_out(mh, mv, POL_A));
    q_b.push_back(model_out(mh, mv, POL_B));

    chk("a_pixel_h", if_a.PIXEL_H, mh);
    chk("a_pixel_v", if_a.PIXEL_V, mv);
    chk("b_pixel_h", if_b.PIXEL_H, mh);
    chk("b_pixel_v", if_b.PIXEL_V, mv);
    chk("a_frame_start", if_a.FRAME_START, prev_origin);
    chk("b_frame_start", if_b.FRAME_START, prev_origin);

    // frame period, hsync count per frame, sync widths (instance A, active-high)
    hs_now = if_a.VGA_HSYNC;
    vs_now = if_a.VGA_VSYNC;
    if (hs_now && !hs_prev) hs_rise_cnt++;
    if (hs_now) hs_run++;
    else if (hs_prev) begin
      chk("hsync_width", hs_run, HS);
      hs_run = 0;
    end
    if (vs_now) vs_run++;
    else if (vs_prev) begin
      chk("vsync_width", vs_run, VS * HT);
      vs_run = 0;
    end
    hs_prev = hs_now;
    vs_prev = vs_now;
    if (if_a.FRAME_START) begin
      if (last_fs >= 0) begin
        chk("frame_period", cyc - last_fs, HT * VT);
        chk("hsync_per_frame", hs_rise_cnt, VT);
      end
      last_fs = cyc;
      hs_rise_cnt = 0;
    end

    // engine: answer for the coordinates LAT cycles ago
    hist_a.push_back(int'(if_a.PIXEL_H));
    hist_b.push_back(int'(if_b.PIXEL_H));
    if (hist_a.size() > LAT_A) if_a.PIXEL = engine(hist_a.pop_front());
    else                       if_a.PIXEL = 3'b111;
    if (hist_b.size() > LAT_B) if_b.PIXEL = engine(hist_b.pop_front());
    else                       if_b.PIXEL = 3'b111;

    prev_origin = (mh == 0) && (mv == 0);
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    cyc++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge VGA_CLOCK);
      #1;
      do_cycle();
    end
  endtask

  initial begin
    int guard;
    if_a.PIXEL = 3'b111;
    if_b.PIXEL = 3'b111;
    RESET = 1'b1;
    repeat (3) @(posedge VGA_CLOCK);
    #1;
    check_reset_pins("por");

    @(negedge VGA_CLOCK);
    RESET = 1'b0;
    start_model();
    do_cycle();
    run_cycles(3 * HT * VT + 7);

    // mid-frame reset at (5,3)
    guard = 0;
    while (!(mh == 5 && mv == 3) && guard < 2 * HT * VT) begin
      run_cycles(1);
      guard++;
    end
    chk("midreset_reached", guard < 2 * HT * VT, 1);
    #2;
    RESET = 1'b1;
    #1;
    check_reset_pins("midrst");
    repeat (5) @(posedge VGA_CLOCK);
    #1;
    check_reset_pins("midrst_hold");
    @(negedge VGA_CLOCK);
    RESET = 1'b0;
    start_model();
    do_cycle();
    run_cycles(2 * HT * VT + 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
